// File: rtl/frame_buffer_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// frame_buffer_arbiter_pkg
// Shared definitions for the frame-buffer arbiter and its channel trackers:
//   - arb_state_t  : arbiter FSM state encoding
//   - CH_WR/CH_RD  : channel-select encoding used for the command direction
//                    and for the round-robin "last served" record
//   - compose_addr : builds a memory word address from a frame-buffer index
//                    placed directly above an in-frame word offset
// ----------------------------------------------------------------------------
package frame_buffer_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_CMD  = 2'd2,
        ST_BUSY = 2'd3
    } arb_state_t;

    localparam logic CH_WR = 1'b1;
    localparam logic CH_RD = 1'b0;

    // Result is 32 bits wide; callers keep the low ADDR_W bits. The offset
    // must already be zero above offset_w.
    function automatic logic [31:0] compose_addr(input logic [1:0]  index,
                                                 input logic [31:0] offset,
                                                 input int          offset_w);
        logic [31:0] idx_ext;
        idx_ext = {30'd0, index};
        return (idx_ext << offset_w) | offset;
    endfunction

endpackage

// File: rtl/frame_buffer_arbiter_tracker.sv
// ----------------------------------------------------------------------------
// fb_channel_tracker
// Per-channel frame progress for one side of the frame buffer (camera write
// or display read). Holds the active flag, frame-buffer index, word offset
// and words remaining, plus a pending new-frame request that arrived while
// this channel owned the command port.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   frame_start   pulse: a new frame begins on this channel
//   addr_index    frame-buffer index captured with frame_start
//   fifo_avail    words the channel FIFO can supply / absorb right now
//   busy          this channel currently owns the command port
//   burst_done    the burst issued for this channel has completed
//   len           next burst length, min(BURST_LEN, remaining)
//   eligible      channel may be granted a burst of length len
//   addr          next burst start word address
//   frame_done    one-cycle pulse when the final burst of a frame completes
// ----------------------------------------------------------------------------
module fb_channel_tracker
    import frame_buffer_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int OFFSET_W    = 20,
    parameter int FRAME_WORDS = 786432,
    parameter int BURST_LEN   = 64,
    parameter int LEN_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [1:0]        addr_index,
    input  logic [LEN_W-1:0]  fifo_avail,
    input  logic              busy,
    input  logic              burst_done,
    output logic [LEN_W-1:0]  len,
    output logic              eligible,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_done
);

    // One extra bit so a full frame count fits.
    localparam int REM_W = OFFSET_W + 1;
    localparam logic [REM_W-1:0] FRAME_REM = REM_W'(FRAME_WORDS);
    localparam logic [REM_W-1:0] BURST_REM = REM_W'(BURST_LEN);

    logic                active_q;
    logic                pending_q;
    logic [1:0]          index_q;
    logic [1:0]          pending_index_q;
    logic [OFFSET_W-1:0] offset_q;
    logic [REM_W-1:0]    remaining_q;
    logic                frame_done_q;

    logic [LEN_W-1:0]    len_c;
    logic [REM_W-1:0]    rem_next;
    logic [OFFSET_W-1:0] offset_next;
    logic [31:0]         addr_full;

    always_comb begin
        len_c = LEN_W'(BURST_LEN);
        if (remaining_q < BURST_REM) begin
            len_c = remaining_q[LEN_W-1:0];
        end
    end

    assign rem_next    = remaining_q - REM_W'(len_c);
    assign offset_next = offset_q + OFFSET_W'(len_c);
    assign addr_full   = compose_addr(index_q, 32'(offset_q), OFFSET_W);

    assign len        = len_c;
    // The remaining != 0 term keeps zero-length bursts from ever issuing.
    assign eligible   = active_q && (remaining_q != '0) && (fifo_avail >= len_c);
    assign addr       = addr_full[ADDR_W-1:0];
    assign frame_done = frame_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q        <= 1'b0;
            pending_q       <= 1'b0;
            index_q         <= 2'd0;
            pending_index_q <= 2'd0;
            offset_q        <= '0;
            remaining_q     <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (burst_done) begin
                if (pending_q || frame_start) begin
                    // A new frame requested during the burst replaces the
                    // normal post-burst advance of the old frame.
                    index_q     <= frame_start ? addr_index : pending_index_q;
                    offset_q    <= '0;
                    remaining_q <= FRAME_REM;
                    active_q    <= 1'b1;
                    pending_q   <= 1'b0;
                end else begin
                    offset_q    <= offset_next;
                    remaining_q <= rem_next;
                    if (rem_next == '0) begin
                        active_q     <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
            end else if (frame_start) begin
                if (busy) begin
                    pending_q       <= 1'b1;
                    pending_index_q <= addr_index;
                end else begin
                    index_q     <= addr_index;
                    offset_q    <= '0;
                    remaining_q <= FRAME_REM;
                    active_q    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// ----------------------------------------------------------------------------
// frame_buffer_arbiter
// Schedules bursts from the camera write channel and the display read channel
// onto one memory-controller command port, round-robin when both are ready.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wr_frame_start/index      camera frame begin pulse and frame-buffer index
//   wr_fifo_level             words waiting in the write FIFO
//   rd_frame_start/index      display frame begin pulse and frame-buffer index
//   rd_fifo_space             free words in the read FIFO
//   mem_cmd_valid/ready       command handshake to the memory controller
//   mem_cmd_wr/addr/len       command payload (direction, start, length)
//   mem_done                  pulse: outstanding burst finished
//   wr_grant/rd_grant         a burst of that direction is outstanding
//   wr_frame_done/rd_frame_done  pulse when a channel's last burst completes
// ----------------------------------------------------------------------------
module frame_buffer_arbiter
    import frame_buffer_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int OFFSET_W    = 20,
    parameter int FRAME_WORDS = 786432,
    parameter int BURST_LEN   = 64,
    parameter int LEN_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_frame_start,
    input  logic [1:0]        wr_addr_index,
    input  logic [LEN_W-1:0]  wr_fifo_level,
    input  logic              rd_frame_start,
    input  logic [1:0]        rd_addr_index,
    input  logic [LEN_W-1:0]  rd_fifo_space,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [LEN_W-1:0]  mem_cmd_len,
    input  logic              mem_done,
    output logic              wr_grant,
    output logic              rd_grant,
    output logic              wr_frame_done,
    output logic              rd_frame_done
);

    // Parameter sanity: the frame must fit the offset field, a full burst
    // must fit the length field, and the index must fit above the offset.
    generate
        if ((FRAME_WORDS > (1 << OFFSET_W)) || (FRAME_WORDS < 1) ||
            (BURST_LEN < 1) || (BURST_LEN >= (1 << LEN_W)) ||
            (ADDR_W < OFFSET_W + 2) || (ADDR_W > 32) || (LEN_W > OFFSET_W + 1)) begin : g_bad_params
            $error("frame_buffer_arbiter: inconsistent parameters");
        end
    endgenerate

    arb_state_t        state_q, state_d;
    logic              last_served_q;
    logic              cmd_wr_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [LEN_W-1:0]  cmd_len_q;

    logic [LEN_W-1:0]  wr_len, rd_len;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_eligible, rd_eligible;
    logic              any_eligible;
    logic              arb_sel;
    logic              port_owned;
    logic              wr_busy, rd_busy;
    logic              wr_burst_done, rd_burst_done;

    fb_channel_tracker #(
        .ADDR_W      (ADDR_W),
        .OFFSET_W    (OFFSET_W),
        .FRAME_WORDS (FRAME_WORDS),
        .BURST_LEN   (BURST_LEN),
        .LEN_W       (LEN_W)
    ) u_wr_tracker (
        .clk         (clk),
        .rst         (rst),
        .frame_start (wr_frame_start),
        .addr_index  (wr_addr_index),
        .fifo_avail  (wr_fifo_level),
        .busy        (wr_busy),
        .burst_done  (wr_burst_done),
        .len         (wr_len),
        .eligible    (wr_eligible),
        .addr        (wr_addr),
        .frame_done  (wr_frame_done)
    );

    fb_channel_tracker #(
        .ADDR_W      (ADDR_W),
        .OFFSET_W    (OFFSET_W),
        .FRAME_WORDS (FRAME_WORDS),
        .BURST_LEN   (BURST_LEN),
        .LEN_W       (LEN_W)
    ) u_rd_tracker (
        .clk         (clk),
        .rst         (rst),
        .frame_start (rd_frame_start),
        .addr_index  (rd_addr_index),
        .fifo_avail  (rd_fifo_space),
        .busy        (rd_busy),
        .burst_done  (rd_burst_done),
        .len         (rd_len),
        .eligible    (rd_eligible),
        .addr        (rd_addr),
        .frame_done  (rd_frame_done)
    );

    // Round-robin: with both ready, serve the channel not served last.
    always_comb begin
        any_eligible = wr_eligible || rd_eligible;
        arb_sel      = CH_RD;
        if (wr_eligible && rd_eligible) begin
            arb_sel = (last_served_q == CH_RD) ? CH_WR : CH_RD;
        end else if (wr_eligible) begin
            arb_sel = CH_WR;
        end
    end

    // A channel counts as busy from the ARB cycle that picks it until its
    // burst completes, so a frame_start in that window is deferred instead
    // of changing the addr/len being registered for the command.
    assign port_owned    = (state_q == ST_CMD) || (state_q == ST_BUSY);
    assign wr_busy       = (port_owned && (cmd_wr_q == CH_WR)) ||
                           ((state_q == ST_ARB) && any_eligible && (arb_sel == CH_WR));
    assign rd_busy       = (port_owned && (cmd_wr_q == CH_RD)) ||
                           ((state_q == ST_ARB) && any_eligible && (arb_sel == CH_RD));
    assign wr_burst_done = (state_q == ST_BUSY) && mem_done && (cmd_wr_q == CH_WR);
    assign rd_burst_done = (state_q == ST_BUSY) && mem_done && (cmd_wr_q == CH_RD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_served_q <= CH_RD;
            cmd_wr_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_ARB) && any_eligible) begin
                cmd_wr_q   <= arb_sel;
                cmd_addr_q <= (arb_sel == CH_WR) ? wr_addr : rd_addr;
                cmd_len_q  <= (arb_sel == CH_WR) ? wr_len  : rd_len;
            end
            if ((state_q == ST_BUSY) && mem_done) begin
                last_served_q <= cmd_wr_q;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_cmd_valid = 1'b0;
        wr_grant      = 1'b0;
        rd_grant      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_eligible) state_d = ST_ARB;
            end
            ST_ARB: begin
                // Eligibility may have dropped since IDLE (FIFO drained).
                state_d = any_eligible ? ST_CMD : ST_IDLE;
            end
            ST_CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                wr_grant = (cmd_wr_q == CH_WR);
                rd_grant = (cmd_wr_q == CH_RD);
                if (mem_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_cmd_wr   = cmd_wr_q;
    assign mem_cmd_addr = cmd_addr_q;
    assign mem_cmd_len  = cmd_len_q;

endmodule
